mul_seq: RTL and testbench



---
 rtl/mul_seq_if.sv | 20 ++
 rtl/mul_seq.sv | 98 +++++++++
 tb/tb_mul_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// Operand/result bundle for the sequential sign-magnitude multiplier.
// MUL_SEQ_OVF_EN adds the o_OV overflow flag.
interface mul_seq_if #(parameter int WIDTH = 3);
  logic               i_start;
  logic [WIDTH-1:0]   i_A;
  logic [WIDTH-1:0]   i_B;
  logic               o_busy;
  logic               o_done;
  logic [2*WIDTH-2:0] o_res;
  logic               o_Z;
`ifdef MUL_SEQ_OVF_EN
  logic               o_OV;

  modport master (output i_start, i_A, i_B, input o_busy, o_done, o_res, o_Z, o_OV);
  modport slave  (input i_start, i_A, i_B, output o_busy, o_done, o_res, o_Z, o_OV);
`else
  modport master (output i_start, i_A, i_B, input o_busy, o_done, o_res, o_Z);
  modport slave  (input i_start, i_A, i_B, output o_busy, o_done, o_res, o_Z);
`endif
endinterface

// File: rtl/mul_seq.sv
// Shift-and-add sign-magnitude multiplier, one multiplier bit per clock; done M cycles after start.
// Optional overflow flag o_OV under macro MUL_SEQ_OVF_EN.
module mul_seq #(
  parameter int WIDTH = 3
) (
  input  logic     i_clk,
  input  logic     i_rst,
  mul_seq_if.slave bus
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [2*M-1:0]  acc, mcand, acc_sum;
  logic [M-1:0]    mplier;
  logic [CW-1:0]   count;
  logic            sgn;
  logic            accept, last;
  logic            done_q, z_q;
  logic [2*M:0]    res_q;
`ifdef MUL_SEQ_OVF_EN
  logic            ov_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    acc_sum   = acc + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: if (bus.i_start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (count == LAST) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      sgn    <= 1'b0;
      done_q <= 1'b0;
      z_q    <= 1'b0;
      res_q  <= '0;
`ifdef MUL_SEQ_OVF_EN
      ov_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mcand  <= {{M{1'b0}}, bus.i_A[M-1:0]};
        mplier <= bus.i_B[M-1:0];
        sgn    <= bus.i_A[WIDTH-1] ^ bus.i_B[WIDTH-1];
        acc    <= '0;
        count  <= '0;
      end else if (state == RUN) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        if (last) begin
          // A zero magnitude always reports a positive sign.
          res_q  <= {sgn & (acc_sum != '0), acc_sum};
          z_q    <= (acc_sum == '0);
          done_q <= 1'b1;
`ifdef MUL_SEQ_OVF_EN
          ov_q   <= |acc_sum[2*M-1:M];
`endif
        end
      end
    end
  end

  assign bus.o_busy = (state == RUN);
  assign bus.o_done = done_q;
  assign bus.o_res  = res_q;
  assign bus.o_Z    = z_q;
`ifdef MUL_SEQ_OVF_EN
  assign bus.o_OV   = ov_q;
`endif

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: countdown/arith reference model checked every cycle, plus directed literal checks.
module tb_mul_seq;
  localparam int M = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(3)) bus ();
  mul_seq #(.WIDTH(3)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  mul_seq_if #(.WIDTH(5)) bus5 ();
  mul_seq #(.WIDTH(5)) dut5 (.i_clk(clk), .i_rst(rst), .bus(bus5));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic       m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0, m_ov = 1'b0;
  logic [4:0] m_res = '0, p_res = '0;
  logic       p_z = 1'b0, p_ov = 1'b0;
  int         m_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    else passed++;
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    int mag;
    if (rst) begin
      m_busy = 0; m_done = 0; m_res = '0; m_z = 0; m_ov = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_busy = 0; m_res = p_res; m_z = p_z; m_ov = p_ov;
        end
      end else if (bus.i_start) begin
        mag    = int'(bus.i_A[1:0]) * int'(bus.i_B[1:0]);
        p_res  = {(bus.i_A[2] ^ bus.i_B[2]) && (mag != 0), 4'(mag)};
        p_z    = (mag == 0);
        p_ov   = (mag > 3);
        m_left = M;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.o_busy, m_busy);
      check("done", bus.o_done, m_done);
      check("res", bus.o_res, m_res);
      check("z", bus.o_Z, m_z);
`ifdef MUL_SEQ_OVF_EN
      check("ov", bus.o_OV, m_ov);
`endif
    end
  end

  task automatic op(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    bus.i_A = a; bus.i_B = b; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.o_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", bus.o_done, 1'b1);
  endtask

  initial begin
    int n, t0;
    bus.i_start = 0; bus.i_A = '0; bus.i_B = '0;
    bus5.i_start = 0; bus5.i_A = '0; bus5.i_B = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_res", bus.o_res, 5'b0);
    rst = 1'b0;

    // +3 x -3
    op(3'b011, 3'b111);
    check("busy_first", bus.o_busy, 1'b1);
    wait_done(n);
    check("lat_w3", n, 2);
    check("res_m9", bus.o_res, 5'b11001);
    check("z_m9", bus.o_Z, 1'b0);
`ifdef MUL_SEQ_OVF_EN
    check("ov_m9", bus.o_OV, 1'b1);
`endif

    // -0 x +2, then +1 x -1
    op(3'b100, 3'b010);
    wait_done(n);
    check("res_zero", bus.o_res, 5'b00000);
    check("z_zero", bus.o_Z, 1'b1);
    op(3'b001, 3'b101);
    wait_done(n);
    check("res_m1", bus.o_res, 5'b10001);
    check("z_m1", bus.o_Z, 1'b0);
`ifdef MUL_SEQ_OVF_EN
    check("ov_m1", bus.o_OV, 1'b0);
`endif

    // Start during RUN is ignored
    @(negedge clk);
    bus.i_A = 3'b010; bus.i_B = 3'b010; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_A = 3'b011; bus.i_B = 3'b011;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(n);
    check("res_p4", bus.o_res, 5'b00100);
    @(negedge clk);
    check("no_extra_busy", bus.o_busy, 1'b0);

    // Reset mid-operation aborts
    op(3'b011, 3'b001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.o_busy, 1'b0);
    check("abort_res", bus.o_res, 5'b0);
    check("abort_z", bus.o_Z, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_nodone", bus.o_done, 1'b0);
    op(3'b001, 3'b001);
    wait_done(n);
    check("lat_p1", n, 2);
    check("res_p1", bus.o_res, 5'b00001);

    // Back-to-back: start in the done cycle
    op(3'b010, 3'b101);
    wait_done(n);
    check("res_m2", bus.o_res, 5'b10010);
    t0 = cyc;
    bus.i_A = 3'b011; bus.i_B = 3'b011; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("done_pulse1", bus.o_done, 1'b0);
    wait_done(n);
    check("b2b_gap", cyc - t0, 3);
    check("res_p9", bus.o_res, 5'b01001);
    @(negedge clk);
    check("done_pulse2", bus.o_done, 1'b0);

    // WIDTH=5: +15 x -15
    bus5.i_A = 5'b01111; bus5.i_B = 5'b11111; bus5.i_start = 1'b1;
    @(negedge clk);
    bus5.i_start = 1'b0;
    n = 0;
    while (bus5.o_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w5_done", bus5.o_done, 1'b1);
    check("w5_lat", n, 4);
    check("w5_res", bus5.o_res, 9'b1_11100001);
    check("w5_z", bus5.o_Z, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
endmodule
